// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// Inserts a bubble and freezes PC and IF/ID when EX holds a load whose destination ID reads.
module id_ex_pipe_reg #(
  parameter int CTRL_W    = 10,
  parameter int MEMRD_BIT = 3,
  parameter int REGWR_BIT = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [31:0]       pc_plus4_i,
  input  logic [31:0]       rs_data_i,
  input  logic [31:0]       rt_data_i,
  input  logic [31:0]       imm_ext_i,
  input  logic [4:0]        rs_addr_i,
  input  logic [4:0]        rt_addr_i,
  input  logic [4:0]        rd_addr_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [31:0]       pc_plus4_o,
  output logic [31:0]       rs_data_o,
  output logic [31:0]       rt_data_o,
  output logic [31:0]       imm_ext_o,
  output logic [4:0]        rs_addr_o,
  output logic [4:0]        rt_addr_o,
  output logic [4:0]        rd_addr_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              hazard_o,
  output logic              pc_write_o,
  output logic              if_id_write_o
);

  // Control-bit indices must address distinct bits inside the bundle.
  if (MEMRD_BIT >= CTRL_W || REGWR_BIT >= CTRL_W || MEMRD_BIT == REGWR_BIT) begin : g_bad_ctrl_bits
    $error("id_ex_pipe_reg: MEMRD_BIT/REGWR_BIT out of range or overlapping");
  end

  logic              vld_p1;
  logic [31:0]       pc_plus4_p1;
  logic [31:0]       rs_data_p1;
  logic [31:0]       rt_data_p1;
  logic [31:0]       imm_ext_p1;
  logic [4:0]        rs_addr_p1;
  logic [4:0]        rt_addr_p1;
  logic [4:0]        rd_addr_p1;
  logic [CTRL_W-1:0] ctrl_p1;
  logic              hazard;
  logic              freeze;

  // $0 is hard-wired zero, so a load targeting it never creates a dependency.
  always_comb begin
    hazard = vld_p1 & ctrl_p1[MEMRD_BIT] & (rt_addr_p1 != 5'd0) & valid_i &
             ((rt_addr_p1 == rs_addr_i) | (rt_addr_p1 == rt_addr_i));
    freeze = hazard | stall_i;
  end

  // ID -> EX stage boundary
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1      <= 1'b0;
      ctrl_p1     <= '0;
      pc_plus4_p1 <= '0;
      rs_data_p1  <= '0;
      rt_data_p1  <= '0;
      imm_ext_p1  <= '0;
      rs_addr_p1  <= '0;
      rt_addr_p1  <= '0;
      rd_addr_p1  <= '0;
    end else if (flush_i || (!stall_i && hazard)) begin
      vld_p1      <= 1'b0;
      ctrl_p1     <= '0;
      pc_plus4_p1 <= pc_plus4_i;
      rs_data_p1  <= rs_data_i;
      rt_data_p1  <= rt_data_i;
      imm_ext_p1  <= imm_ext_i;
      rs_addr_p1  <= rs_addr_i;
      rt_addr_p1  <= rt_addr_i;
      rd_addr_p1  <= rd_addr_i;
    end else if (!stall_i) begin
      vld_p1      <= valid_i;
      ctrl_p1     <= valid_i ? ctrl_i : '0;
      pc_plus4_p1 <= pc_plus4_i;
      rs_data_p1  <= rs_data_i;
      rt_data_p1  <= rt_data_i;
      imm_ext_p1  <= imm_ext_i;
      rs_addr_p1  <= rs_addr_i;
      rt_addr_p1  <= rt_addr_i;
      rd_addr_p1  <= rd_addr_i;
    end
  end

  assign valid_o       = vld_p1;
  assign ctrl_o        = ctrl_p1;
  assign pc_plus4_o    = pc_plus4_p1;
  assign rs_data_o     = rs_data_p1;
  assign rt_data_o     = rt_data_p1;
  assign imm_ext_o     = imm_ext_p1;
  assign rs_addr_o     = rs_addr_p1;
  assign rt_addr_o     = rt_addr_p1;
  assign rd_addr_o     = rd_addr_p1;
  assign hazard_o      = hazard & ~rst_i;
  assign pc_write_o    = rst_i | ~freeze;
  assign if_id_write_o = rst_i | ~freeze;

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register for the 5-stage CPU; sits directly downstream of the sign-extend unit.
- Captures the 32-bit extended immediate, register-file read data, register addresses, PC+4 and decoded control for the EX stage.
- Contains load-use hazard detection: inserts a bubble and freezes PC and IF/ID on a load-use dependency.
- Also supports an external stall (hold) and a flush (branch taken).

Parameters:
- CTRL_W, 10, width of the decoded control bundle
- MEMRD_BIT, 3, bit index of MemRead inside ctrl_i/ctrl_o
- REGWR_BIT, 0, bit index of RegWrite inside ctrl_i/ctrl_o

Ports:
- clk_i  input  1  clock; all state updates on its rising edge
- rst_i  input  1  reset, asynchronous, active-high
- stall_i  input  1  external hold: all EX-stage registers keep their value
- flush_i  input  1  squash: the next EX content is a bubble
- valid_i  input  1  ID stage holds a real instruction
- pc_plus4_i  input  32  PC+4 of the ID instruction
- rs_data_i  input  32  register-file read port 1
- rt_data_i  input  32  register-file read port 2
- imm_ext_i  input  32  extended immediate from the sign-extend unit
- rs_addr_i  input  5  instr[25:21]
- rt_addr_i  input  5  instr[20:16]
- rd_addr_i  input  5  instr[15:11]
- ctrl_i  input  CTRL_W  decoded control bundle
- valid_o  output  1  EX stage holds a real instruction
- pc_plus4_o, rs_data_o, rt_data_o, imm_ext_o  output  32 each  registered copies
- rs_addr_o, rt_addr_o, rd_addr_o  output  5 each  registered copies
- ctrl_o  output  CTRL_W  registered control; all zero on a bubble
- hazard_o  output  1  load-use hazard detected this cycle (combinational)
- pc_write_o  output  1  0 freezes the PC
- if_id_write_o  output  1  0 freezes the IF/ID register

Behaviour:
- Reset (asynchronous, while rst_i=1):
  - all registered outputs are 0, including valid_o and ctrl_o.
  - hazard_o=0, pc_write_o=1, if_id_write_o=1.
  - Takes effect immediately, including mid-stall or mid-hazard.
- Hazard detect (combinational from the current EX registers and ID inputs):
  - hazard_o = valid_o & ctrl_o[MEMRD_BIT] & (rt_addr_o != 0) & valid_i & ((rt_addr_o == rs_addr_i) | (rt_addr_o == rt_addr_i)).
  - Register $0 never causes a hazard.
- Freeze outputs:
  - pc_write_o = if_id_write_o = ~(hazard_o | stall_i).
  - flush_i does not freeze; the upstream stage flushes IF/ID itself.
- Clock-edge priority, highest first:
  1. flush_i=1: bubble. valid_o=0, ctrl_o=0; data/address fields load the inputs (don't-care content).
  2. stall_i=1: hold every register, including valid_o.
  3. hazard_o=1: bubble. valid_o=0, ctrl_o=0; the ID instruction stays in ID because of the freeze.
  4. Otherwise: load all inputs. valid_o=valid_i; ctrl_o = valid_i ? ctrl_i : 0.
- Latency: exactly 1 cycle from ID inputs to the EX outputs.
- No arithmetic: imm_ext_i passes through bit-exact, with no re-extension.
- A bubble causes a hazard for at most one cycle: after it, valid_o=0, so hazard_o drops and the dependent instruction advances with forwarding from MEM.
- Flush during hazard: flush wins. EX gets a bubble, hazard_o still freezes PC and IF/ID for that cycle.
- Stall during hazard: hold. hazard_o persists and the freeze persists.

Test Plan:
- Reset: assert rst_i mid-cycle with valid data loaded -> valid_o=0, ctrl_o=0, imm_ext_o=0 immediately, without waiting for a clock edge; pc_write_o=1.
- Pass-through: valid_i=1, imm_ext_i=32'hFFFF8000, ctrl_i=10'h3FF, rs_data_i=32'h12345678 -> one edge later the outputs match exactly; valid_o=1; hazard_o=0.
- Load-use: EX holds a lw (ctrl bit3=1, rt_addr_o=8), ID has rs_addr_i=8 -> hazard_o=1, pc_write_o=0, if_id_write_o=0; next edge valid_o=0, ctrl_o=0; following edge the ID instruction loads and hazard_o=0.
- $0 and non-load cases:
  - lw with rt_addr_o=0 and rs_addr_i=0 -> hazard_o=0.
  - Non-load (bit3=0) with matching rt -> hazard_o=0.
- Stall: stall_i=1 for 3 cycles while the inputs change -> outputs frozen at the pre-stall values; pc_write_o=0 during the stall; a normal load resumes after it.
- Flush vs hazard: hazard condition and flush_i=1 in the same cycle -> next edge valid_o=0, ctrl_o=0; pc_write_o=0 during that cycle.
